// File: rtl/led_pattern_gen.sv
// LED pattern generator: count-up/down, rotate and bounce patterns stepped at a runtime period.
// New period/mode are taken over a valid/ready handshake and applied only on a step boundary.
module led_pattern_gen #(
  parameter int          WIDTH          = 8,
  parameter int          CNT_WIDTH      = 32,
  parameter int unsigned DEFAULT_PERIOD = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [1:0]           cfg_mode,
  output logic [WIDTH-1:0]     LED,
  output logic                 tick,
  output logic [1:0]           cur_mode
);

  // dir  | meaning
  // UP   | bounce moving toward the MSB
  // DN   | bounce moving toward bit 0
  localparam logic       DIR_UP = 1'b0;
  localparam logic       DIR_DN = 1'b1;

  localparam logic [1:0] MODE_UP  = 2'd0;
  localparam logic [1:0] MODE_DN  = 2'd1;
  localparam logic [1:0] MODE_ROT = 2'd2;

  localparam logic [WIDTH-1:0]     LED_ONE  = WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] PER_RST  = CNT_WIDTH'(DEFAULT_PERIOD);

  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] pend_period;
  logic [1:0]           pend_mode;
  logic                 pend_v;
  logic                 dir;
  logic                 accept;
  logic                 wrap;
  logic                 apply;
  logic [WIDTH-1:0]     step_led;
  logic                 step_dir;
  logic [WIDTH-1:0]     seed_led;

  assign cfg_ready = ~pend_v;
  assign accept    = cfg_valid & ~pend_v;
  assign wrap      = enable & (count == (period_q - CNT_ONE));
  // A pending config is applied at the next wrap, or at once while frozen.
  assign apply     = pend_v & (wrap | ~enable);

  always_comb begin
    step_led = LED;
    step_dir = dir;
    case (cur_mode)
      MODE_UP:  step_led = LED + LED_ONE;
      MODE_DN:  step_led = LED - LED_ONE;
      MODE_ROT: step_led = (LED << 1) | (LED >> (WIDTH - 1));
      default: begin
        if (WIDTH > 1) begin
          if (dir == DIR_UP) begin
            step_led = LED << 1;
            if (step_led[WIDTH-1]) step_dir = DIR_DN;
          end else begin
            step_led = LED >> 1;
            if (step_led[0]) step_dir = DIR_UP;
          end
        end
      end
    endcase
  end

  always_comb begin
    case (pend_mode)
      MODE_UP: seed_led = '0;
      MODE_DN: seed_led = '1;
      default: seed_led = LED_ONE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count       <= '0;
      period_q    <= PER_RST;
      cur_mode    <= MODE_UP;
      LED         <= '0;
      dir         <= DIR_UP;
      tick        <= 1'b0;
      pend_v      <= 1'b0;
      pend_period <= PER_RST;
      pend_mode   <= MODE_UP;
    end else begin
      tick <= 1'b0;
      if (accept) begin
        pend_v      <= 1'b1;
        pend_period <= (cfg_period == '0) ? CNT_ONE : cfg_period;
        pend_mode   <= cfg_mode;
      end
      if (apply) begin
        period_q <= pend_period;
        cur_mode <= pend_mode;
        count    <= '0;
        LED      <= seed_led;
        dir      <= DIR_UP;
        pend_v   <= 1'b0;
        tick     <= 1'b1;
      end else if (wrap) begin
        count <= '0;
        LED   <= step_led;
        dir   <= step_dir;
        tick  <= 1'b1;
      end else if (enable) begin
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen (WIDTH=4, DEFAULT_PERIOD=4): expected LED/mode/spacing per tick are
// queued as stimulus is driven and checked by a monitor when the DUT pulses tick.
module tb_led_pattern_gen;

  logic        CLK;
  logic        RST;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_period;
  logic [1:0]  cfg_mode;
  logic [3:0]  LED;
  logic        tick;
  logic [1:0]  cur_mode;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] led;
    logic [1:0] mode;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   gap = 0;

  led_pattern_gen #(.WIDTH(4), .CNT_WIDTH(32), .DEFAULT_PERIOD(4)) dut (
    .CLK(CLK), .RST(RST), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .LED(LED), .tick(tick), .cur_mode(cur_mode)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Scoreboard: every tick must match the next queued step; gap is cycles since the previous tick.
  always begin
    @(posedge CLK);
    #1;
    if (RST) begin
      gap = 0;
    end else begin
      gap++;
      if (tick) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_tick: LED=%h mode=%0d", LED, cur_mode);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (LED !== e.led) begin
            miscompares++;
            $display("FAIL step_led: got %h expected %h", LED, e.led);
          end
          vectors++;
          if (cur_mode !== e.mode) begin
            miscompares++;
            $display("FAIL step_mode: got %0d expected %0d", cur_mode, e.mode);
          end
          if (e.gap != 0) begin
            vectors++;
            if (gap != e.gap) begin
              miscompares++;
              $display("FAIL step_spacing: got %0d cycles expected %0d (LED %h)", gap, e.gap, e.led);
            end
          end
        end
        gap = 0;
      end
    end
  end

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic push(input logic [3:0] led, input logic [1:0] mode, input int g);
    exp_t x;
    x.led = led; x.mode = mode; x.gap = g;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
  endtask

  task automatic offer(input logic [1:0] mode, input logic [31:0] per);
    cfg_valid = 1'b1; cfg_mode = mode; cfg_period = per;
  endtask

  task automatic test_reset();
    RST = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    repeat (3) cyc();
    vectors++;
    if (LED !== 4'h0) begin miscompares++; $display("FAIL reset_led: got %h expected 0", LED); end
    vectors++;
    if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b expected 0", tick); end
    vectors++;
    if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    vectors++;
    if (cur_mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode: got %0d expected 0", cur_mode); end
  endtask

  task automatic test_count_up();
    for (int i = 1; i <= 17; i++) push(4'(i % 16), 2'd0, 4);
    RST = 1'b0; enable = 1'b1;
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL count_up_timeout: %0d steps missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_cfg_down();
    cyc();
    offer(2'd1, 32'd2);
    push(4'hF, 2'd1, 4); push(4'hE, 2'd1, 2); push(4'hD, 2'd1, 2);
    cyc();
    cfg_valid = 1'b0;
    vectors++;
    if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL cfg_ready_low: got %b expected 0", cfg_ready); end
    vectors++;
    if (LED !== 4'h1) begin miscompares++; $display("FAIL cfg_no_glitch: got %h expected 1", LED); end
    cyc();
    vectors++;
    if ({cfg_ready, LED} !== {1'b0, 4'h1}) begin
      miscompares++; $display("FAIL cfg_pending: got ready=%b LED=%h expected ready=0 LED=1", cfg_ready, LED);
    end
    cyc();
    vectors++;
    if ({tick, cfg_ready, cur_mode, LED} !== {1'b1, 1'b1, 2'd1, 4'hF}) begin
      miscompares++;
      $display("FAIL cfg_apply: got tick=%b ready=%b mode=%0d LED=%h expected 1 1 1 F", tick, cfg_ready, cur_mode, LED);
    end
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL cfg_down_timeout: %0d steps missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    offer(2'd3, 32'd1);
    push(4'h1, 2'd3, 2);
    push(4'h2, 2'd3, 1); push(4'h4, 2'd3, 1); push(4'h8, 2'd3, 1); push(4'h4, 2'd3, 1);
    push(4'h2, 2'd3, 1); push(4'h1, 2'd3, 1); push(4'h2, 2'd3, 1);
    cyc();
    cfg_valid = 1'b0;
    vectors++;
    if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL bounce_ready: got %b expected 0", cfg_ready); end
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL bounce_timeout: %0d steps missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_rotate_freeze();
    offer(2'd2, 32'd1);
    push(4'h4, 2'd3, 1); push(4'h1, 2'd2, 1);
    push(4'h2, 2'd2, 1); push(4'h4, 2'd2, 1); push(4'h8, 2'd2, 1); push(4'h1, 2'd2, 1);
    cyc();
    cfg_valid = 1'b0;
    wait_drain();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      vectors++;
      if ({tick, LED} !== {1'b0, 4'h1}) begin
        miscompares++; $display("FAIL freeze_%0d: got tick=%b LED=%h expected tick=0 LED=1", i, tick, LED);
      end
    end
    enable = 1'b1;
    push(4'h2, 2'd2, 11); push(4'h4, 2'd2, 1); push(4'h8, 2'd2, 1);
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rotate_timeout: %0d steps missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_period_zero();
    enable = 1'b0;
    offer(2'd0, 32'd0);
    push(4'h0, 2'd0, 2);
    cyc();
    vectors++;
    if ({tick, cfg_ready, LED} !== {1'b0, 1'b0, 4'h8}) begin
      miscompares++; $display("FAIL frozen_capture: got tick=%b ready=%b LED=%h expected 0 0 8", tick, cfg_ready, LED);
    end
    offer(2'd1, 32'd5);
    cyc();
    vectors++;
    if ({tick, cfg_ready, cur_mode, LED} !== {1'b1, 1'b1, 2'd0, 4'h0}) begin
      miscompares++;
      $display("FAIL frozen_apply: got tick=%b ready=%b mode=%0d LED=%h expected 1 1 0 0", tick, cfg_ready, cur_mode, LED);
    end
    cfg_valid = 1'b0; enable = 1'b1;
    push(4'h1, 2'd0, 1); push(4'h2, 2'd0, 1); push(4'h3, 2'd0, 1);
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL period_zero_timeout: %0d steps missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_pending();
    offer(2'd2, 32'd8);
    push(4'h4, 2'd0, 1); push(4'h1, 2'd2, 1);
    cyc();
    cfg_valid = 1'b0;
    wait_drain();
    cyc();
    offer(2'd1, 32'd2);
    cyc();
    cfg_valid = 1'b0;
    vectors++;
    if ({cfg_ready, LED} !== {1'b0, 4'h1}) begin
      miscompares++; $display("FAIL pre_reset: got ready=%b LED=%h expected ready=0 LED=1", cfg_ready, LED);
    end
    RST = 1'b1;
    cyc();
    vectors++;
    if ({tick, cfg_ready, cur_mode, LED} !== {1'b0, 1'b1, 2'd0, 4'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: got tick=%b ready=%b mode=%0d LED=%h expected 0 1 0 0", tick, cfg_ready, cur_mode, LED);
    end
    RST = 1'b0;
    push(4'h1, 2'd0, 4); push(4'h2, 2'd0, 4);
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL post_reset_timeout: %0d steps missing, expected 0", exp_q.size()); end
  endtask

  initial begin
    RST = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_mode = '0;
    test_reset();
    test_count_up();
    test_cfg_down();
    test_bounce();
    test_rotate_freeze();
    test_period_zero();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
